// File: rtl/rom_arbiter_pkg.sv
// Shared types and defaults for the two-port ROM read arbiter.
// Holds the FSM state encoding and the default ADDR_W/DATA_W constants.
package rom_arbiter_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/rom_arb_rr2.sv
// Two-way winner select; one-hot grant, pointer breaks ties.
// Ports: i_req[1:0] requests, i_last last winner index, o_gnt[1:0] grant.
module rom_arb_rr2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  logic w_both;

  assign w_both = &i_req;

  // On a tie the requester that did not win last time gets it.
  always_comb begin
    o_gnt = 2'b00;
    priority case (1'b1)
      w_both:   o_gnt = i_last ? 2'b01 : 2'b10;
      i_req[0]: o_gnt = 2'b01;
      i_req[1]: o_gnt = 2'b10;
      default:  o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/rom_arbiter.sv
// Two requesters share one synchronous ROM: IDLE->READ->CAPT->RESP FSM.
// Ports: clk, rst (sync, active-high), req0/1, addr0/1 in; gnt0/1,
// rvalid0/1, rdata, rom_en, rom_addr, busy out; rom_data in.
// Macro ROM_ARBITER_FIXED_PRIO_EN: requester 0 always wins ties.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  state_t            r_state;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_rv0;
  logic              r_rv1;
  logic [DATA_W-1:0] r_rdata;
  logic              r_en;
  logic [ADDR_W-1:0] r_addr;
  logic              r_busy;
  logic              r_win;

  logic [1:0]        w_gnt;
  logic              w_ptr;
  logic              w_any;

  assign w_any = req0 | req1;

`ifdef ROM_ARBITER_FIXED_PRIO_EN
  // Pretend requester 1 won last so requester 0 wins every tie.
  assign w_ptr = 1'b1;
`else
  logic r_last;
  assign w_ptr = r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_any &&
                 (r_state == IDLE || r_state == RESP)) begin
      r_last <= w_gnt[1];
    end
  end
`endif

  rom_arb_rr2 u_arb (
    .i_req  ({req1, req0}),
    .i_last (w_ptr),
    .o_gnt  (w_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_rv0   <= 1'b0;
      r_rv1   <= 1'b0;
      r_rdata <= '0;
      r_en    <= 1'b0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_win   <= 1'b0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_rv0  <= 1'b0;
      r_rv1  <= 1'b0;
      r_en   <= 1'b0;
      unique case (r_state)
        IDLE, RESP: begin
          if (w_any) begin
            r_win   <= w_gnt[1];
            r_addr  <= w_gnt[1] ? addr1 : addr0;
            r_en    <= 1'b1;
            r_gnt0  <= w_gnt[0];
            r_gnt1  <= w_gnt[1];
            r_busy  <= 1'b1;
            r_state <= READ;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        READ: begin
          r_state <= CAPT;
        end
        CAPT: begin
          r_rdata <= rom_data;
          r_rv0   <= ~r_win;
          r_rv1   <= r_win;
          r_state <= RESP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt0     = r_gnt0;
  assign gnt1     = r_gnt1;
  assign rvalid0  = r_rv0;
  assign rvalid1  = r_rv1;
  assign rdata    = r_rdata;
  assign rom_en   = r_en;
  assign rom_addr = r_addr;
  assign busy     = r_busy;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios plus random
// traffic against a transaction-level model and a ~addr ROM.
module tb_rom_arbiter;

  logic       clk = 1'b0;
  logic       rst_v;
  logic [1:0] req_v;
  logic [3:0] addr_v [2];
  logic       gnt0, gnt1, rvalid0, rvalid1, rom_en, busy;
  logic [3:0] rdata, rom_addr;
  logic [3:0] rom_q = 4'h0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk)
    if (rom_en) rom_q <= ~rom_addr;

  rom_arbiter dut (
    .clk      (clk),
    .rst      (rst_v),
    .req0     (req_v[0]),
    .req1     (req_v[1]),
    .addr0    (addr_v[0]),
    .addr1    (addr_v[1]),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata    (rdata),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_q),
    .busy     (busy)
  );

  // model: a read decided at edge tg shows gnt after tg, rvalid after
  // tg+2, and the arbiter is free to decide again at edge tg+3
  int         t = 0;
  bit         m_inf;
  int         m_tg;
  int         m_win;
  int         m_ptr;
  logic [3:0] m_addr;
  logic [1:0] e_gnt, e_rv;
  logic       e_en, e_busy;
  logic [3:0] e_addr, e_rdata;
  bit   [1:0] drop_p;
  bit         cont;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_step();
    int w;
    if (rst_v) begin
      m_inf   = 0;
      m_ptr   = 1;
      e_gnt   = 0;
      e_rv    = 0;
      e_en    = 0;
      e_addr  = 0;
      e_busy  = 0;
      e_rdata = 0;
    end else begin
      e_gnt = 0;
      e_rv  = 0;
      e_en  = 0;
      if (m_inf && t == m_tg + 2) begin
        e_rv[m_win] = 1'b1;
        e_rdata     = ~m_addr;
      end
      if (!m_inf || t >= m_tg + 3) begin
        if (req_v != 2'b00) begin
          if (req_v == 2'b11) begin
`ifdef ROM_ARBITER_FIXED_PRIO_EN
            w = 0;
`else
            w = 1 - m_ptr;
`endif
          end else begin
            w = req_v[1] ? 1 : 0;
          end
          m_ptr    = w;
          m_win    = w;
          m_addr   = addr_v[w];
          m_tg     = t;
          m_inf    = 1;
          e_gnt[w] = 1'b1;
          e_en     = 1'b1;
          e_addr   = addr_v[w];
          e_busy   = 1'b1;
        end else begin
          m_inf  = 0;
          e_busy = 0;
        end
      end else begin
        e_busy = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    t++;
    model_step();
    #1;
    chk("gnt0", gnt0, e_gnt[0]);
    chk("gnt1", gnt1, e_gnt[1]);
    chk("rvalid0", rvalid0, e_rv[0]);
    chk("rvalid1", rvalid1, e_rv[1]);
    chk("rom_en", rom_en, e_en);
    chk("rom_addr", rom_addr, e_addr);
    chk("busy", busy, e_busy);
    chk("rdata", rdata, e_rdata);
    chk("gnt_onehot", gnt0 & gnt1, 0);
    chk("rv_onehot", rvalid0 & rvalid1, 0);
    // keep req up through its gnt cycle, release it one cycle later
    for (int i = 0; i < 2; i++) begin
      if (drop_p[i]) begin
        drop_p[i] = 0;
        if (cont) addr_v[i] = 4'($urandom_range(0, 15));
        else req_v[i] = 1'b0;
      end
      if (e_gnt[i]) drop_p[i] = 1;
    end
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    tick();
    tick();
    rst_v = 1'b0;
  endtask

  initial begin
    rst_v     = 1'b1;
    req_v     = 2'b00;
    addr_v[0] = 4'h0;
    addr_v[1] = 4'h0;
    drop_p    = 0;
    cont      = 0;
    m_inf     = 0;
    m_ptr     = 1;

    // reset state
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", rom_addr, 0);

    // single request to 0x2
    req_v[0] = 1; addr_v[0] = 4'h2;
    tick(); chk("s1_gnt0", gnt0, 1);
    tick();
    tick(); chk("s1_rv0", rvalid0, 1);
    chk("s1_rdata", rdata, 4'hD);
    tick(); tick();

    // simultaneous after reset: 0 first, then 1
    do_reset();
    req_v = 2'b11; addr_v[0] = 4'h2; addr_v[1] = 4'hC;
    tick(); chk("s2_gnt0", gnt0, 1);
    tick();
    tick(); chk("s2_rdata0", rdata, 4'hD);
    tick(); chk("s2_gnt1", gnt1, 1);
    tick();
    tick(); chk("s2_rv1", rvalid1, 1);
    chk("s2_rdata1", rdata, 4'h3);
    tick(); tick();

    // both held continuously
    do_reset();
    cont  = 1;
    req_v = 2'b11;
    for (int k = 0; k < 15; k++) tick();
    cont  = 0;
    req_v = 2'b00;
    drop_p = 0;
    for (int k = 0; k < 4; k++) tick();

    // reset during CAPT of a read to 0x5
    do_reset();
    req_v[0] = 1; addr_v[0] = 4'h5;
    tick(); chk("s4_gnt0", gnt0, 1);
    tick();
    rst_v = 1'b1;
    tick();
    chk("s4_rv0", rvalid0, 0);
    chk("s4_rdata", rdata, 0);
    chk("s4_busy", busy, 0);
    rst_v = 1'b0;
    for (int k = 0; k < 4; k++) tick();

    // idle stretch
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("idle_en", rom_en, 0);
      chk("idle_busy", busy, 0);
    end

    // random traffic with occasional reset
    for (int k = 0; k < 500; k++) begin
      rst_v = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < 2; i++)
        if (!req_v[i] && !drop_p[i] && $urandom_range(0, 2) == 0) begin
          req_v[i]  = 1'b1;
          addr_v[i] = 4'($urandom_range(0, 15));
        end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 4, ROM address width.
REQ-002 SHALL have parameter DATA_W, 4, ROM data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req0/req1  input  1 each  read request; held high until the matching grant.
REQ-006 SHALL have ports addr0/addr1  input  ADDR_W each  request address; stable while the matching req is high.
REQ-007 SHALL have ports gnt0/gnt1  output  1 each  one-cycle pulse; request accepted and ROM read issued this cycle.
REQ-008 SHALL have ports rvalid0/rvalid1  output  1 each  one-cycle pulse; rdata holds that requester's result.
REQ-009 SHALL have port rdata  output  DATA_W  registered read result, shared by both requesters.
REQ-010 SHALL have port rom_en  output  1  ROM enable.
REQ-011 SHALL have port rom_addr  output  ADDR_W  ROM address.
REQ-012 SHALL have port rom_data  input  DATA_W  ROM output, valid one cycle after the ROM samples rom_en=1.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement the FSM IDLE -> READ -> CAPT -> RESP.
REQ-015 In IDLE or RESP, with any req high, SHALL select a winner, latch its address and index, and go to READ; otherwise SHALL go to (or stay in) IDLE.
REQ-016 In READ (one cycle) SHALL drive rom_en=1, rom_addr=latched address, and gnt of the winner =1.
REQ-017 In CAPT (one cycle) SHALL load rom_data into rdata at the closing edge.
REQ-018 In RESP (one cycle) SHALL drive rvalid of the winner =1 and re-arbitrate per REQ-015.
REQ-019 Latency SHALL be: req sampled at edge N -> gnt during cycle N+1 -> rvalid during cycle N+3; back-to-back service period is 3 cycles.
REQ-020 When both req are high, SHALL grant the requester not granted last (round-robin); last-grant pointer updates at each grant.
REQ-021 A single req SHALL be granted regardless of the pointer.
REQ-022 A req still high in the cycle its gnt is high SHALL be consumed and not treated as a new request.
REQ-023 rdata SHALL hold its value until the next CAPT.
REQ-024 Outside READ, rom_en SHALL be 0 and rom_addr SHALL hold its last value.
REQ-025 Gnt and rvalid SHALL be one-hot-or-zero at all times.

Reset
REQ-026 On rst=1 at a clock edge SHALL enter IDLE and set gnt0/1=0, rvalid0/1=0, rdata=0, rom_en=0, rom_addr=0, busy=0, and the last-grant pointer to requester 1.
REQ-027 Reset during READ, CAPT or RESP SHALL discard the in-flight read; no rvalid is emitted for it.
REQ-028 rst SHALL take priority over all requests in the same cycle.

Configuration
REQ-029 SHALL honour macro ROM_ARBITER_FIXED_PRIO_EN; when defined, requester 0 always wins ties and the pointer is unused.
REQ-030 Without ROM_ARBITER_FIXED_PRIO_EN, SHALL use round-robin per REQ-020.

Structure
REQ-031 Package rom_arbiter_pkg SHALL hold the state encoding (IDLE, READ, CAPT, RESP) and the default ADDR_W/DATA_W constants.
REQ-032 Winner selection SHALL be a sub-module rom_arb_rr2 (2-way, pointer input, one-hot grant output).

Verification
REQ-033 Bench ROM model SHALL be a synchronous 16x4 ROM with content data = ~addr, enabled by rom_en.
REQ-034 Scenario: req0=1, addr0=4'h2 -> gnt0 in cycle N+1, rvalid0 in N+3, rdata=4'hD.
REQ-035 Scenario: req0 and req1 raised together (addr 4'h2, 4'hC) after reset -> gnt0 first (rdata 4'hD), gnt1 3 cycles later (rdata 4'h3); with ROM_ARBITER_FIXED_PRIO_EN and req0 re-raised, req0 is served again before req1.
REQ-036 Scenario: both held continuously -> grants alternate 0,1,0,1 every 3 cycles.
REQ-037 Scenario: rst=1 asserted in the CAPT cycle of a read to 4'h5 -> no rvalid, rdata=0, busy=0 next cycle.
REQ-038 Scenario: no requests for 10 cycles -> rom_en=0, busy=0 throughout.
